// File: rtl/shot_display.sv
// shot_display: output stage for the shot counter.
//   Shows the 4-bit count (0..15) in decimal on a 2-digit multiplexed
//   seven-segment display, blanking a leading zero. A rising edge on buzz
//   plays BEEP_COUNT beeps on the speaker, and the display blinks off
//   during the gaps between beeps.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   count[3:0] : shot counter value (binary)
//   buzz       : alert request (level; only a low->high edge triggers)
//   seg[6:0]   : segments {a,b,c,d,e,f,g}, active-high, registered
//   an[1:0]    : digit enables, active-low; an[0]=ones, an[1]=tens
//   speaker    : beep drive, active-high, registered
//   busy       : high while a beep pattern plays, registered
module shot_display #(
  parameter int DIG_DIV    = 1000,
  parameter int BEEP_LEN   = 50,
  parameter int GAP_LEN    = 50,
  parameter int BEEP_COUNT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] count,
  input  logic       buzz,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       speaker,
  output logic       busy
);

  localparam int DIV_W  = (DIG_DIV > 1) ? $clog2(DIG_DIV) : 1;
  localparam int TMR_MX = (BEEP_LEN > GAP_LEN) ? BEEP_LEN : GAP_LEN;
  localparam int TMR_W  = (TMR_MX > 1) ? $clog2(TMR_MX) : 1;
  localparam int LEFT_W = $clog2(BEEP_COUNT + 1);

  typedef enum logic [1:0] {IDLE, BEEP, GAP} state_t;

  state_t              state, state_nxt;
  logic [TMR_W-1:0]    tmr, tmr_nxt;
  logic [LEFT_W-1:0]   left, left_nxt;
  logic [DIV_W-1:0]    div;
  logic                sel;
  logic [3:0]          cnt_q;
  logic                buzz_q;
  logic                rise;

  logic                tens_on;
  logic [3:0]          ones;
  logic [6:0]          seg_d;
  logic [1:0]          an_d;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'b1111110;
      4'd1:    seg_code = 7'b0110000;
      4'd2:    seg_code = 7'b1101101;
      4'd3:    seg_code = 7'b1111001;
      4'd4:    seg_code = 7'b0110011;
      4'd5:    seg_code = 7'b1011011;
      4'd6:    seg_code = 7'b1011111;
      4'd7:    seg_code = 7'b1110000;
      4'd8:    seg_code = 7'b1111111;
      4'd9:    seg_code = 7'b1111011;
      default: seg_code = 7'b0000000;
    endcase
  endfunction

  assign rise = buzz & ~buzz_q;

  // Input capture and refresh mux
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      buzz_q <= 1'b1;  // a buzz held high across reset release is not an edge
      div    <= '0;
      sel    <= 1'b0;
    end else begin
      cnt_q  <= count;
      buzz_q <= buzz;
      if (div == DIV_W'(DIG_DIV - 1)) begin
        div <= '0;
        sel <= ~sel;
      end else begin
        div <= div + 1'b1;
      end
    end
  end

  // Beep FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      tmr   <= '0;
      left  <= '0;
    end else begin
      state <= state_nxt;
      tmr   <= tmr_nxt;
      left  <= left_nxt;
    end
  end

  // Beep FSM next state; rises outside IDLE are dropped, not queued
  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    left_nxt  = left;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = BEEP;
          tmr_nxt   = '0;
          left_nxt  = LEFT_W'(BEEP_COUNT);
        end
      end
      BEEP: begin
        if (tmr == TMR_W'(BEEP_LEN - 1)) begin
          left_nxt  = left - 1'b1;
          tmr_nxt   = '0;
          state_nxt = (left == LEFT_W'(1)) ? IDLE : GAP;
        end else begin
          tmr_nxt = tmr + 1'b1;
        end
      end
      GAP: begin
        if (tmr == TMR_W'(GAP_LEN - 1)) begin
          state_nxt = BEEP;
          tmr_nxt   = '0;
        end else begin
          tmr_nxt = tmr + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Decode and digit select
  always_comb begin
    tens_on = (cnt_q >= 4'd10);
    ones    = tens_on ? (cnt_q - 4'd10) : cnt_q;
    seg_d   = 7'b0000000;
    an_d    = 2'b11;
    if (!sel) begin
      an_d  = 2'b10;
      seg_d = seg_code(ones);
    end else if (tens_on) begin
      an_d  = 2'b01;
      seg_d = seg_code(4'd1);
    end
    // blink: digits off during gaps, segment data untouched
    if (state == GAP) an_d = 2'b11;
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg     <= 7'b0000000;
      an      <= 2'b11;
      speaker <= 1'b0;
      busy    <= 1'b0;
    end else begin
      seg     <= seg_d;
      an      <= an_d;
      speaker <= (state == BEEP);
      busy    <= (state != IDLE);
    end
  end

endmodule

// File: tb/tb_shot_display.sv
// tb_shot_display: directed bench for shot_display with
// DIG_DIV=4, BEEP_LEN=3, GAP_LEN=2, BEEP_COUNT=3.
module tb_shot_display;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] count = 4'd0;
  logic       buzz = 1'b1;
  logic [6:0] seg;
  logic [1:0] an;
  logic       speaker;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int ec    = 0;  // edges since last reset release
  int nb, nr, ns;
  logic prev_b;

  localparam logic [6:0] S0 = 7'b1111110;
  localparam logic [6:0] S1 = 7'b0110000;
  localparam logic [6:0] S2 = 7'b1101101;
  localparam logic [6:0] S3 = 7'b1111001;
  localparam logic [6:0] S5 = 7'b1011011;
  localparam logic [6:0] S7 = 7'b1110000;

  bit spk_tab [15] = '{0,1,1,1,0,0,1,1,1,0,0,1,1,1,0};
  bit gap_tab [15] = '{0,0,0,0,1,1,0,0,0,1,1,0,0,0,0};

  shot_display #(
    .DIG_DIV(4), .BEEP_LEN(3), .GAP_LEN(2), .BEEP_COUNT(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .count(count), .buzz(buzz),
    .seg(seg), .an(an), .speaker(speaker), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, ec, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ec++;
  endtask

  // Output register at edge e shows digit phase ((e-1)/4)%2: 0=ones, 1=tens.
  function automatic int ph(input int e);
    return ((e - 1) / 4) % 2;
  endfunction

  task automatic disp(input string tag, input logic [6:0] o, input logic [6:0] t,
                      input bit ht, input bit gap);
    logic [1:0] ea;
    logic [6:0] es;
    if (ph(ec) == 0) begin
      ea = 2'b10; es = o;
    end else if (ht) begin
      ea = 2'b01; es = t;
    end else begin
      ea = 2'b11; es = 7'b0000000;
    end
    if (gap) ea = 2'b11;
    chk({tag, "_an"}, {30'd0, an}, {30'd0, ea});
    chk({tag, "_seg"}, {25'd0, seg}, {25'd0, es});
  endtask

  task automatic clr();
    nb = 0; nr = 0; ns = 0; prev_b = busy;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (busy) nb++;
      if (speaker) ns++;
      if (busy && !prev_b) nr++;
      prev_b = busy;
    end
  endtask

  initial begin
    // reset with buzz high
    rst_n = 1'b0; buzz = 1'b1; count = 4'd0;
    tick(); tick();
    chk("rst_seg", seg, 7'b0000000);
    chk("rst_an", an, 2'b11);
    chk("rst_spk", speaker, 1'b0);
    chk("rst_busy", busy, 1'b0);

    // single digit, buzz still high through release
    count = 4'd7; rst_n = 1'b1; ec = 0;
    tick();
    chk("sd_e1_seg", seg, S0);
    chk("sd_e1_an", an, 2'b10);
    for (int i = 0; i < 15; i++) begin
      tick();
      disp("sd", S7, 7'd0, 1'b0, 1'b0);
      chk("sd_busy", busy, 1'b0);
    end

    // two digits
    count = 4'd12; buzz = 1'b0;
    tick();
    disp("td17", S7, S1, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      tick();
      disp("td12", S2, S1, 1'b1, 1'b0);
    end
    count = 4'd15;
    tick();
    disp("td25", S2, S1, 1'b1, 1'b0);
    tick();
    disp("td26", S5, S1, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      disp("td15", S5, S1, 1'b1, 1'b0);
    end

    // one-cycle buzz pulse
    buzz = 1'b1;
    tick();
    buzz = 1'b0;
    for (int j = 0; j < 15; j++) begin
      if (j > 0) tick();
      chk("pl_spk", speaker, spk_tab[j]);
      chk("pl_busy", busy, (j >= 1 && j <= 13) ? 1'b1 : 1'b0);
      disp("pl", S5, S1, 1'b1, gap_tab[j]);
    end

    // buzz held high for 40 cycles
    clr();
    buzz = 1'b1;
    run(40);
    buzz = 1'b0;
    run(5);
    chk("held_busy_cyc", nb, 13);
    chk("held_rises", nr, 1);
    chk("held_spk_cyc", ns, 9);

    // second pulse 5 cycles after first rise is ignored
    clr();
    buzz = 1'b1; run(1);
    buzz = 1'b0; run(4);
    buzz = 1'b1; run(1);
    buzz = 1'b0; run(25);
    chk("dbl_busy_cyc", nb, 13);
    chk("dbl_rises", nr, 1);

    // fresh pulse after busy fell starts a new pattern
    clr();
    buzz = 1'b1; run(1);
    buzz = 1'b0; run(20);
    chk("new_busy_cyc", nb, 13);
    chk("new_rises", nr, 1);
    chk("new_spk_cyc", ns, 9);

    // reset during the second beep
    buzz = 1'b1;
    tick();
    buzz = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("mid_pre_spk", speaker, 1'b1);
    chk("mid_pre_busy", busy, 1'b1);
    rst_n = 1'b0; count = 4'd3;
    tick();
    chk("mid_rst_spk", speaker, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_an", an, 2'b11);
    chk("mid_rst_seg", seg, 7'b0000000);
    rst_n = 1'b1; ec = 0;
    tick();
    chk("mid_e1_seg", seg, S0);
    chk("mid_e1_an", an, 2'b10);
    for (int i = 0; i < 7; i++) begin
      tick();
      disp("mid3", S3, 7'd0, 1'b0, 1'b0);
      chk("mid_idle", busy, 1'b0);
      chk("mid_idle_spk", speaker, 1'b0);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("mid_idle2", busy, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
